// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the input-conditioning stage.
//   DEBOUNCE_DEFAULT : hold time in clk cycles used in silicon
//   SIM_DEBOUNCE     : short hold time so simulations stay fast
//   cnt_width(n)     : counter width able to hold 0..n-1
package input_cond_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT = 50000;
    localparam int unsigned SIM_DEBOUNCE     = 4;

    function automatic int cnt_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer -> hold counter -> registered edge pulses.
//   clk, rst  : clock, async active-high reset
//   i_en      : count enable (synchronizer keeps running when low)
//   i_raw     : asynchronous pin
//   o_level   : debounced level
//   o_rise    : one-cycle pulse on accepted 0->1
//   o_fall    : one-cycle pulse on accepted 1->0
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int unsigned CYCLES    = SIM_DEBOUNCE,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = cnt_width(CYCLES);

    logic             r_s0;
    logic             r_s1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             w_hit;

    // Last count before acceptance; the counter is cleared right after, so it
    // never needs to represent CYCLES itself.
    assign w_hit = (r_cnt == CNT_W'(CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_cnt   <= '0;
            r_level <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s0   <= i_raw;
            r_s1   <= r_s0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_en) begin
                if (r_s1 == r_level) begin
                    // any return to the current level forfeits the count
                    r_cnt <= '0;
                end else if (w_hit) begin
                    r_level <= r_s1;
                    r_cnt   <= '0;
                    r_rise  <= r_s1;
                    r_fall  <= ~r_s1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/input_debouncer.sv
// Input-conditioning stage: every raw pin is synchronized, debounced and
// edge-detected independently before any downstream logic sees it.
//   clk, rst  : clock, async active-high reset
//   en        : debounce-count enable
//   raw_in    : asynchronous raw pins
//   level_out : debounced levels
//   rise_out  : one-cycle pulses on accepted 0->1
//   fall_out  : one-cycle pulses on accepted 1->0
module input_debouncer
    import input_cond_pkg::*;
#(
    parameter int unsigned          WIDTH           = 8,
    parameter int unsigned          DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter logic [WIDTH-1:0]     RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .CYCLES    (DEBOUNCE_CYCLES),
            .RESET_VAL (RESET_VAL[i])
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .i_en    (en),
            .i_raw   (raw_in[i]),
            .o_level (level_out[i]),
            .o_rise  (rise_out[i]),
            .o_fall  (fall_out[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;
    import input_cond_pkg::*;

    localparam int           W  = 8;
    localparam int           N  = SIM_DEBOUNCE;
    localparam logic [W-1:0] RV = 8'h00;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b1;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] level_out, rise_out, fall_out;

    input_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(N), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .raw_in(raw_in),
        .level_out(level_out), .rise_out(rise_out), .fall_out(fall_out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: synchronizer as a two-deep sample delay line; a bit is
    // accepted once the last N enabled samples all disagree with its level.
    logic [W-1:0] m_level, m_rise, m_fall;
    logic [W-1:0] rawq[$];
    bit           win[W][$];

    task automatic model_reset();
        m_level = RV;
        m_rise  = '0;
        m_fall  = '0;
        rawq.delete();
        rawq.push_back('0);
        rawq.push_back('0);
        for (int i = 0; i < W; i++) win[i].delete();
    endtask

    task automatic model_edge(input logic [W-1:0] r, input logic e);
        logic [W-1:0] s;
        bit           all_diff;
        s = rawq.pop_front();
        rawq.push_back(r);
        m_rise = '0;
        m_fall = '0;
        if (e) begin
            for (int i = 0; i < W; i++) begin
                win[i].push_back(s[i]);
                if (win[i].size() > N) void'(win[i].pop_front());
                if (win[i].size() == N) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < N; k++)
                        if (win[i][k] == m_level[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_level[i] = s[i];
                        if (s[i]) m_rise[i] = 1'b1;
                        else      m_fall[i] = 1'b1;
                        win[i].delete();
                    end
                end
            end
        end
    endtask

    // Drive inputs, take one edge, compare whole output state to the model.
    task automatic step(input logic [W-1:0] r, input logic e);
        raw_in = r;
        en     = e;
        @(posedge clk);
        model_edge(r, e);
        #1;
        vectors++;
        if ({level_out, rise_out, fall_out} !== {m_level, m_rise, m_fall}) begin
            miscompares++;
            $display("FAIL model: got lvl=%h rise=%h fall=%h, expected lvl=%h rise=%h fall=%h",
                     level_out, rise_out, fall_out, m_level, m_rise, m_fall);
        end
    endtask

    // Assert reset between edges; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_level"}, level_out, RV);
        chk({tag, "_rise"},  rise_out,  '0);
        chk({tag, "_fall"},  fall_out,  '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] raw;
        logic         en;
        logic [W-1:0] lvl;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [W-1:0] acc;
        logic [W-1:0] r;
        int           rk, fk, hi, nr, seg;
        logic         e, en_pulse;

        // clean rise on bit 0: sampled at entry 0, accepted at entry 5
        for (int i = 0; i < 8; i++) tbl[i] = '{8'h01, 1'b1, 8'h00, 8'h00, 8'h00};
        tbl[5] = '{8'h01, 1'b1, 8'h01, 8'h01, 8'h00};
        tbl[6] = '{8'h01, 1'b1, 8'h01, 8'h00, 8'h00};
        tbl[7] = '{8'h01, 1'b1, 8'h01, 8'h00, 8'h00};

        raw_in = 8'hFF;
        repeat (2) @(posedge clk);
        #2;
        do_reset("rst_async");

        raw_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].raw, tbl[i].en);
            chk($sformatf("tbl%0d_lvl", i),  level_out, tbl[i].lvl);
            chk($sformatf("tbl%0d_rise", i), rise_out,  tbl[i].rise);
            chk($sformatf("tbl%0d_fall", i), fall_out,  tbl[i].fall);
        end
        repeat (8) step(8'h00, 1'b1);
        chk("bit0_back_low", level_out, 8'h00);

        // 3-cycle glitch on bit 3 is discarded
        acc = '0;
        for (int k = 0; k < 13; k++) begin
            step((k < 3) ? 8'h08 : 8'h00, 1'b1);
            acc |= level_out | rise_out | fall_out;
        end
        chk("glitch3_bit3", acc & 8'h08, 8'h00);

        // 4-cycle pulse on bit 3 is accepted, rise and fall 4 cycles apart
        rk = -1; fk = -1; hi = 0;
        for (int k = 0; k < 16; k++) begin
            step((k < 4) ? 8'h08 : 8'h00, 1'b1);
            if (rise_out[3]) rk = k;
            if (fall_out[3]) fk = k;
            hi += int'(level_out[3]);
        end
        chk("glitch4_rise_at", rk, 5);
        chk("glitch4_fall_at", fk, 9);
        chk("glitch4_high_cycles", hi, 4);

        // bounce on bit 2: one rise, 5 cycles after the final 0->1 sample
        rk = -1; nr = 0;
        for (int k = 0; k < 15; k++) begin
            step((k < 5 && (k % 2) == 1) ? 8'h00 : 8'h04, 1'b1);
            if (rise_out[2]) begin rk = k; nr++; end
        end
        chk("bounce_rise_count", nr, 1);
        chk("bounce_rise_at", rk, 9);
        repeat (8) step(8'h00, 1'b1);

        // enable freeze on bit 5: 2 counts, 10 frozen cycles, 2 more to accept
        rk = -1; en_pulse = 1'b0;
        for (int k = 0; k < 20; k++) begin
            e = !(k >= 4 && k < 14);
            step(8'h20, e);
            if (rise_out[5]) rk = k;
            if (!e && (rise_out != 0 || fall_out != 0)) en_pulse = 1'b1;
            if (k == 14) chk("freeze_lvl_before", level_out[5], 1'b0);
        end
        chk("freeze_rise_at", rk, 15);
        chk("freeze_no_pulse_while_off", en_pulse, 1'b0);
        repeat (8) step(8'h00, 1'b1);

        // multi-bit simultaneous acceptance
        for (int k = 0; k < 7; k++) begin
            step(8'hA5, 1'b1);
            if (k == 4) chk("multi_lvl_before", level_out, 8'h00);
            if (k == 5) begin
                chk("multi_rise", rise_out, 8'hA5);
                chk("multi_lvl", level_out, 8'hA5);
            end
        end
        repeat (8) step(8'h00, 1'b1);

        // reset at count 3 discards the count; counting restarts after release
        for (int k = 0; k < 5; k++) step(8'hA5, 1'b1);
        do_reset("rst_midcount");
        for (int k = 0; k < 7; k++) begin
            step(8'hA5, 1'b1);
            if (k == 4) chk("restart_lvl_before", level_out, 8'h00);
            if (k == 5) chk("restart_rise", rise_out, 8'hA5);
        end

        // randomized segments against the model
        for (int s = 0; s < 150; s++) begin
            r   = 8'($urandom);
            seg = int'($urandom_range(1, 7));
            for (int k = 0; k < seg; k++) begin
                e = ($urandom_range(0, 9) != 0);
                step(r, e);
            end
            if ($urandom_range(0, 49) == 0) do_reset("rst_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
